// File: rtl/cube_unit.sv
// cube_unit: sequential cube calculator, y = a^3 for an unsigned 8-bit operand.
// A single shift-add multiplier is used twice: first a*a (MUL1), then (a*a)*a (MUL2).
// Each pass consumes one multiplier bit per cycle, LSB first, for 8 cycles.
//
// Ports:
//   clk_i    in   1  clock, rising edge
//   rst_i    in   1  asynchronous active-low reset
//   a_bi     in   8  operand, sampled only when a start is accepted
//   start_i  in   1  start request, level-sampled
//   busy_o   out  2  00 idle, 01 computing a*a, 11 computing (a*a)*a
//   y_bo     out 24  last completed result
module cube_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  a_bi,
  input  logic        start_i,
  output logic [1:0]  busy_o,
  output logic [23:0] y_bo
);

  typedef enum logic [1:0] {StIdle, StMul1, StMul2} state_e;

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] sq_q, sq_d;
  logic [23:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [23:0] y_q, y_d;

  logic [23:0] addend;
  logic [23:0] acc_sum;
  logic        last_bit;

  assign last_bit = (cnt_q == 3'd7);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i)  state_d = StMul1;
      StMul1: if (last_bit) state_d = StMul2;
      StMul2: if (last_bit) state_d = StIdle;
      default:              state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o = 2'b00;
    unique case (state_q)
      StMul1:  busy_o = 2'b01;
      StMul2:  busy_o = 2'b11;
      default: busy_o = 2'b00;
    endcase
  end

  assign y_bo = y_q;

  // Shifted partial product for the current multiplier bit; the multiplicand is the
  // operand in MUL1 and the stored square in MUL2, the multiplier is always the operand.
  always_comb begin
    addend = '0;
    unique case (state_q)
      StMul1:  if (op_q[cnt_q]) addend = {16'h0, op_q} << cnt_q;
      StMul2:  if (op_q[cnt_q]) addend = {8'h0, sq_q} << cnt_q;
      default: addend = '0;
    endcase
  end

  assign acc_sum = acc_q + addend;

  // Datapath next-state
  always_comb begin
    op_d  = op_q;
    sq_d  = sq_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    y_d   = y_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d  = a_bi;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      StMul1: begin
        // Counter wraps 7 -> 0, which is exactly the restart MUL2 needs.
        cnt_d = cnt_q + 3'd1;
        if (last_bit) begin
          sq_d  = acc_sum[15:0];
          acc_d = '0;
        end else begin
          acc_d = acc_sum;
        end
      end
      StMul2: begin
        cnt_d = cnt_q + 3'd1;
        if (last_bit) begin
          y_d   = acc_sum;
          acc_d = '0;
        end else begin
          acc_d = acc_sum;
        end
      end
      default: begin
        acc_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q  <= '0;
      sq_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      y_q   <= '0;
    end else begin
      op_q  <= op_d;
      sq_q  <= sq_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      y_q   <= y_d;
    end
  end

endmodule

// File: tb/tb_cube_unit.sv
// tb_cube_unit: self-checking bench for cube_unit. Expected results come from plain
// arithmetic (v*v*v) and a fixed 16-cycle latency / busy-phase timeline.
module tb_cube_unit;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  a_bi;
  logic        start_i;
  logic [1:0]  busy_o;
  logic [23:0] y_bo;

  int unsigned n_pass;
  int unsigned n_total;

  cube_unit dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .a_bi   (a_bi),
    .start_i(start_i),
    .busy_o (busy_o),
    .y_bo   (y_bo)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] cube(input int unsigned v);
    int unsigned r;
    r = v * v * v;
    return r[23:0];
  endfunction

  // Drive a one-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic issue_start(input logic [7:0] v);
    @(negedge clk_i);
    a_bi    = v;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    a_bi    = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_i   = 1'b0;
    start_i = 1'b0;
    a_bi    = 8'h0;
    #12;
    n_total++;
    if (busy_o !== 2'b00) $display("FAIL reset_busy: got %b, required 00", busy_o);
    else n_pass++;
    n_total++;
    if (y_bo !== 24'h0) $display("FAIL reset_y: got %0d, required 0", y_bo);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    n_total++;
    if (busy_o !== 2'b00) $display("FAIL idle_after_reset: got %b, required 00", busy_o);
    else n_pass++;
  endtask

  // Full busy timeline plus result-hold check for one operand.
  task automatic test_timeline(input logic [7:0] v, input logic [23:0] prev);
    logic [1:0] exp_busy;
    issue_start(v);
    for (int i = 0; i < 16; i++) begin
      exp_busy = (i < 8) ? 2'b01 : 2'b11;
      n_total++;
      if (busy_o !== exp_busy)
        $display("FAIL timeline_busy a=%0d cyc=%0d: got %b, required %b", v, i, busy_o, exp_busy);
      else n_pass++;
      n_total++;
      if (y_bo !== prev)
        $display("FAIL timeline_hold a=%0d cyc=%0d: got %0d, required %0d", v, i, y_bo, prev);
      else n_pass++;
      @(negedge clk_i);
    end
    n_total++;
    if (busy_o !== 2'b00) $display("FAIL timeline_done a=%0d: got %b, required 00", v, busy_o);
    else n_pass++;
    n_total++;
    if (y_bo !== cube(v)) $display("FAIL timeline_y a=%0d: got %0d, required %0d", v, y_bo, cube(v));
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    issue_start(8'd3);
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        a_bi    = 8'd200;
        start_i = 1'b1;
      end
      if (i == 3) start_i = 1'b0;
      n_total++;
      if (busy_o === 2'b00) $display("FAIL ignore_busy cyc=%0d: got 00, required nonzero", i);
      else n_pass++;
      @(negedge clk_i);
    end
    n_total++;
    if (y_bo !== 24'd27) $display("FAIL ignore_y: got %0d, required 27", y_bo);
    else n_pass++;
    @(negedge clk_i);
    n_total++;
    if (busy_o !== 2'b00) $display("FAIL ignore_no_restart: got %b, required 00", busy_o);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    issue_start(8'd10);
    repeat (10) @(negedge clk_i);
    n_total++;
    if (busy_o !== 2'b11) $display("FAIL midrst_in_mul2: got %b, required 11", busy_o);
    else n_pass++;
    n_total++;
    if (y_bo !== 24'd27) $display("FAIL midrst_prev_y: got %0d, required 27", y_bo);
    else n_pass++;
    #2 rst_i = 1'b0;
    #1;
    n_total++;
    if (busy_o !== 2'b00) $display("FAIL midrst_busy: got %b, required 00", busy_o);
    else n_pass++;
    n_total++;
    if (y_bo !== 24'h0) $display("FAIL midrst_y: got %0d, required 0", y_bo);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    n_total++;
    if (busy_o !== 2'b00) $display("FAIL midrst_stays_idle: got %b, required 00", busy_o);
    else n_pass++;
    issue_start(8'd10);
    repeat (16) @(negedge clk_i);
    n_total++;
    if (busy_o !== 2'b00) $display("FAIL midrst_rerun_busy: got %b, required 00", busy_o);
    else n_pass++;
    n_total++;
    if (y_bo !== 24'd1000) $display("FAIL midrst_rerun_y: got %0d, required 1000", y_bo);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk_i);
    a_bi    = 8'd5;
    start_i = 1'b1;
    @(negedge clk_i);
    lat = 0;
    while (busy_o !== 2'b00 && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    n_total++;
    if (lat != 16) $display("FAIL b2b_lat1: got %0d, required 16", lat);
    else n_pass++;
    n_total++;
    if (y_bo !== 24'd125) $display("FAIL b2b_y1: got %0d, required 125", y_bo);
    else n_pass++;
    a_bi = 8'd6;
    @(negedge clk_i);
    n_total++;
    if (busy_o !== 2'b01) $display("FAIL b2b_restart: got %b, required 01", busy_o);
    else n_pass++;
    n_total++;
    if (y_bo !== 24'd125) $display("FAIL b2b_hold: got %0d, required 125", y_bo);
    else n_pass++;
    lat = 0;
    while (busy_o !== 2'b00 && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    start_i = 1'b0;
    n_total++;
    if (lat != 16) $display("FAIL b2b_lat2: got %0d, required 16", lat);
    else n_pass++;
    n_total++;
    if (y_bo !== 24'd216) $display("FAIL b2b_y2: got %0d, required 216", y_bo);
    else n_pass++;
  endtask

  task automatic test_sweep();
    int unsigned order[256];
    int unsigned j;
    int unsigned tmp;
    int lat;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j        = $urandom_range(i, 0);
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      issue_start(8'(order[i]));
      lat = 0;
      while (busy_o !== 2'b00 && lat < 40) begin
        @(negedge clk_i);
        lat++;
      end
      n_total++;
      if (lat != 16) $display("FAIL sweep_lat a=%0d: got %0d, required 16", order[i], lat);
      else n_pass++;
      n_total++;
      if (y_bo !== cube(order[i]))
        $display("FAIL sweep_y a=%0d: got %0d, required %0d", order[i], y_bo, cube(order[i]));
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_timeline(8'd128, 24'd0);
    test_timeline(8'd255, 24'd2097152);
    test_timeline(8'd0, 24'd16581375);
    test_timeline(8'd1, 24'd0);
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
